pipeline_hazard_controller: RTL and testbench

- Central stall/flush/forwarding sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Detects RAW hazards between ID sources and in-flight EXE/MEM destinations, drives ID's hazard input, and generates forwarding selects for EXE.
- Freezes the whole pipe while the data memory is busy, with a wait timeout.
- Defers branch flushes that arrive during a freeze, and keeps saturating stall/freeze statistics.

---
 rtl/pipeline_hazard_controller.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forwarding sequencer for the 5-stage pipeline: RAW detection, operand forwarding,
// data-memory freeze with wait timeout, deferred branch flush, and saturating statistics.
module pipeline_hazard_controller #(
  parameter bit FORWARD_EN = 1'b1,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       wb_dest,
  input  logic             wb_wb_en,
  input  logic [3:0]       exe_src1,
  input  logic [3:0]       exe_src2,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       pending_flush;
  logic       m1, n1, m2, n2, raw;

  // Memory wait FSM: freeze is a combinational function of state and this cycle's handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    mem_timeout  = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LIMIT) begin
          mem_timeout = 1'b1;
          state_nxt   = RUN;
        end else begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign flush = (branch_taken || pending_flush) && !freeze;

  always_comb begin
    m1 = (src1 == exe_dest) && exe_wb_en;
    n1 = (src1 == mem_dest) && mem_wb_en;
    m2 = (src2 == exe_dest) && exe_wb_en && two_src;
    n2 = (src2 == mem_dest) && mem_wb_en && two_src;
    if (FORWARD_EN) raw = exe_mem_r_en && (m1 || m2);
    else            raw = m1 || n1 || m2 || n2;
  end

  assign hazard = raw && !flush;

  function automatic logic [1:0] fwd_sel(input logic [3:0] r);
    if (!FORWARD_EN)                      return 2'b00;
    if ((r == mem_dest) && mem_wb_en)     return 2'b01;
    if ((r == wb_dest) && wb_wb_en)       return 2'b10;
    return 2'b00;
  endfunction

  assign sel_src1 = fwd_sel(exe_src1);
  assign sel_src2 = fwd_sel(exe_src2);

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      wait_cnt      <= 8'd0;
      pending_flush <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (flush)                       pending_flush <= 1'b0;
      else if (branch_taken && freeze) pending_flush <= 1'b1;
    end
  end

  // Statistics saturate rather than wrap; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (hazard && !freeze && stall_cnt != CNT_MAX) stall_cnt  <= stall_cnt + 1'b1;
      if (freeze && freeze_cnt != CNT_MAX)           freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares on negedge.
module tb_pipeline_hazard_controller;

  localparam int TO   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [3:0] src1, src2;
    logic       two_src;
    logic [3:0] exe_dest;
    logic       exe_wb_en, exe_mem_r_en;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic [3:0] wb_dest;
    logic       wb_wb_en;
    logic [3:0] exe_src1, exe_src2;
    logic       branch_taken, mem_req, mem_ready, cnt_clr;
  } stim_t;

  typedef struct {
    int   cyc;
    logic hz1, hz0, fz, fl, to;
    logic [1:0] s1, s2;
    int   sc1, sc0, fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur;

  logic          hazard_a, freeze_a, flush_a, timeout_a;
  logic [1:0]    sel1_a, sel2_a;
  logic [CW-1:0] stall_a, fcnt_a;
  logic          hazard_b, freeze_b, flush_b, timeout_b;
  logic [1:0]    sel1_b, sel2_b;
  logic [CW-1:0] stall_b, fcnt_b;

  pipeline_hazard_controller #(.FORWARD_EN(1'b1), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(cur.rst), .src1(cur.src1), .src2(cur.src2), .two_src(cur.two_src),
    .exe_dest(cur.exe_dest), .exe_wb_en(cur.exe_wb_en), .exe_mem_r_en(cur.exe_mem_r_en),
    .mem_dest(cur.mem_dest), .mem_wb_en(cur.mem_wb_en), .wb_dest(cur.wb_dest),
    .wb_wb_en(cur.wb_wb_en), .exe_src1(cur.exe_src1), .exe_src2(cur.exe_src2),
    .branch_taken(cur.branch_taken), .mem_req(cur.mem_req), .mem_ready(cur.mem_ready),
    .cnt_clr(cur.cnt_clr), .hazard(hazard_a), .freeze(freeze_a), .flush(flush_a),
    .sel_src1(sel1_a), .sel_src2(sel2_a), .mem_timeout(timeout_a),
    .stall_cnt(stall_a), .freeze_cnt(fcnt_a)
  );

  pipeline_hazard_controller #(.FORWARD_EN(1'b0), .TIMEOUT(TO), .CNT_W(CW)) dut_nofwd (
    .clk(clk), .rst(cur.rst), .src1(cur.src1), .src2(cur.src2), .two_src(cur.two_src),
    .exe_dest(cur.exe_dest), .exe_wb_en(cur.exe_wb_en), .exe_mem_r_en(cur.exe_mem_r_en),
    .mem_dest(cur.mem_dest), .mem_wb_en(cur.mem_wb_en), .wb_dest(cur.wb_dest),
    .wb_wb_en(cur.wb_wb_en), .exe_src1(cur.exe_src1), .exe_src2(cur.exe_src2),
    .branch_taken(cur.branch_taken), .mem_req(cur.mem_req), .mem_ready(cur.mem_ready),
    .cnt_clr(cur.cnt_clr), .hazard(hazard_b), .freeze(freeze_b), .flush(flush_b),
    .sel_src1(sel1_b), .sel_src2(sel2_b), .mem_timeout(timeout_b),
    .stall_cnt(stall_b), .freeze_cnt(fcnt_b)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb_q[$];

  // Reference model state: progress of the current memory access, a remembered branch, tallies.
  bit m_waiting = 0;
  int m_waited  = 0;
  bit m_pend    = 0;
  int m_sc1 = 0, m_sc0 = 0, m_fc = 0;

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [3:0] r, input stim_t s);
    if (r == s.mem_dest && s.mem_wb_en) return 2'b01;
    if (r == s.wb_dest && s.wb_wb_en)   return 2'b10;
    return 2'b00;
  endfunction

  function automatic int bump(input int v, input bit inc, input bit clr);
    if (clr) return 0;
    if (inc) return (v + 1 > CMAX) ? CMAX : v + 1;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit   fz, to, fl, m1, n1, m2, n2, hz1, hz0;
    bit   nw;
    int   nwt;
    @(posedge clk);
    #1;
    cur = s;
    cyc++;
    to  = 0;
    nw  = m_waiting;
    nwt = m_waited;
    if (!m_waiting) begin
      fz  = s.mem_req && !s.mem_ready;
      nw  = fz;
      nwt = 1;
    end else if (s.mem_ready) begin
      fz = 0; nw = 0;
    end else if (m_waited == TO) begin
      fz = 0; to = 1; nw = 0;
    end else begin
      fz = 1; nwt = m_waited + 1;
    end
    fl  = (s.branch_taken || m_pend) && !fz;
    m1  = s.src1 == s.exe_dest && s.exe_wb_en;
    n1  = s.src1 == s.mem_dest && s.mem_wb_en;
    m2  = s.two_src && s.src2 == s.exe_dest && s.exe_wb_en;
    n2  = s.two_src && s.src2 == s.mem_dest && s.mem_wb_en;
    hz1 = s.exe_mem_r_en && (m1 || m2) && !fl;
    hz0 = (m1 || n1 || m2 || n2) && !fl;
    e.cyc = cyc; e.hz1 = hz1; e.hz0 = hz0; e.fz = fz; e.fl = fl; e.to = to;
    e.s1  = fwd(s.exe_src1, s); e.s2 = fwd(s.exe_src2, s);
    e.sc1 = m_sc1; e.sc0 = m_sc0; e.fc = m_fc;
    sb_q.push_back(e);
    if (s.rst) begin
      m_waiting = 0; m_waited = 0; m_pend = 0; m_sc1 = 0; m_sc0 = 0; m_fc = 0;
    end else begin
      m_waiting = nw;
      m_waited  = nwt;
      if (fl) m_pend = 0;
      else if (s.branch_taken && fz) m_pend = 1;
      m_sc1 = bump(m_sc1, hz1 && !fz, s.cnt_clr);
      m_sc0 = bump(m_sc0, hz0 && !fz, s.cnt_clr);
      m_fc  = bump(m_fc, fz, s.cnt_clr);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("hazard_fwd",   e.cyc, 32'(hazard_a),  32'(e.hz1));
        check("hazard_nofwd", e.cyc, 32'(hazard_b),  32'(e.hz0));
        check("freeze",       e.cyc, 32'(freeze_a),  32'(e.fz));
        check("freeze_nofwd", e.cyc, 32'(freeze_b),  32'(e.fz));
        check("flush",        e.cyc, 32'(flush_a),   32'(e.fl));
        check("flush_nofwd",  e.cyc, 32'(flush_b),   32'(e.fl));
        check("mem_timeout",  e.cyc, 32'(timeout_a), 32'(e.to));
        check("sel_src1",     e.cyc, 32'(sel1_a),    32'(e.s1));
        check("sel_src2",     e.cyc, 32'(sel2_a),    32'(e.s2));
        check("sel_nofwd",    e.cyc, 32'({sel1_b, sel2_b}), 32'd0);
        check("stall_cnt_fwd",   e.cyc, 32'(stall_a), 32'(e.sc1));
        check("stall_cnt_nofwd", e.cyc, 32'(stall_b), 32'(e.sc0));
        check("freeze_cnt",      e.cyc, 32'(fcnt_a),  32'(e.fc));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rreg();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin : stimulus
    stim_t s, idle;
    idle = '0;
    cur  = idle;
    cur.rst = 1'b1;
    repeat (2) @(posedge clk);

    // No-forwarding RAW on src1, then src2-only match with two_src=0.
    s = idle; s.src1 = 4'd3; s.exe_dest = 4'd3; s.exe_wb_en = 1; drive(s);
    s = idle; s.src1 = 4'd1; s.src2 = 4'd3; s.exe_dest = 4'd3; s.exe_wb_en = 1; drive(s);
    drive(idle);

    // Forwarding priority MEM over WB, then WB alone, then load-use on src2.
    s = idle; s.exe_src1 = 4'd5; s.mem_dest = 4'd5; s.mem_wb_en = 1;
    s.wb_dest = 4'd5; s.wb_wb_en = 1; drive(s);
    s.mem_wb_en = 0; drive(s);
    s = idle; s.exe_mem_r_en = 1; s.exe_wb_en = 1; s.exe_dest = 4'd7;
    s.src1 = 4'd2; s.src2 = 4'd7; s.two_src = 1; drive(s);

    // Memory busy three cycles, ready on the fourth.
    s = idle; s.mem_req = 1;
    repeat (3) drive(s);
    s.mem_ready = 1; drive(s);
    drive(idle);

    // Never ready: timeout abort.
    s = idle; s.mem_req = 1;
    repeat (6) drive(s);
    drive(idle);

    // Branch during the second frozen cycle is deferred to the first unfrozen cycle.
    s = idle; s.mem_req = 1;
    drive(s);
    s.branch_taken = 1; drive(s);
    s.branch_taken = 0; drive(s);
    s.mem_ready = 1; drive(s);
    drive(idle); drive(idle);

    // Saturate the stall counters, then clear together with an active hazard.
    s = idle; s.exe_mem_r_en = 1; s.exe_wb_en = 1; s.exe_dest = 4'd9; s.src1 = 4'd9;
    repeat (CMAX + 20) drive(s);
    s.cnt_clr = 1; drive(s);
    s.cnt_clr = 0; drive(s);
    drive(idle);

    // Reset in MEM_WAIT with a deferred branch pending.
    s = idle; s.mem_req = 1;
    drive(s);
    s.branch_taken = 1; drive(s);
    s.branch_taken = 0; s.rst = 1; drive(s);
    drive(idle); drive(idle);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst          = ($urandom_range(0, 99) == 0);
      s.src1         = rreg();
      s.src2         = rreg();
      s.two_src      = 1'($urandom);
      s.exe_dest     = rreg();
      s.exe_wb_en    = 1'($urandom);
      s.exe_mem_r_en = 1'($urandom);
      s.mem_dest     = rreg();
      s.mem_wb_en    = 1'($urandom);
      s.wb_dest      = rreg();
      s.wb_wb_en     = 1'($urandom);
      s.exe_src1     = rreg();
      s.exe_src2     = rreg();
      s.branch_taken = ($urandom_range(0, 3) == 0);
      s.mem_req      = 1'($urandom);
      s.mem_ready    = ($urandom_range(0, 4) == 0);
      s.cnt_clr      = ($urandom_range(0, 49) == 0);
      drive(s);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", cyc, 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
